// File: rtl/tanh_backward_block_if.sv
// Job bus for tanh_backward_block: run level, dy / y input vectors, valid flag and dx result vector.
interface tanh_backward_block_if #(
  parameter int unsigned HID_DIM = 24,
  parameter int unsigned N_LEN   = 16,
  parameter int unsigned N_LEN_W = 16
);
  logic                       run;
  logic [HID_DIM*N_LEN-1:0]   d;
  logic [HID_DIM*N_LEN_W-1:0] y;
  logic                       valid;
  logic [HID_DIM*N_LEN-1:0]   q;

  modport master (output run, output d, output y, input valid, input q);
  modport slave  (input run, input d, input y, output valid, output q);
endinterface

// File: rtl/tanh_backward_block.sv
// Serial tanh backward pass: dx[i] = dy[i] * (1 - y[i]^2), one element per cycle.
// Define TANH_BACKWARD_ROUND_EN to round half-up on the final shift instead of truncating.
module tanh_backward_block #(
  parameter int unsigned HID_DIM = 24,
  parameter int unsigned N_LEN   = 16,
  parameter int unsigned N_F     = 8,
  parameter int unsigned N_LEN_W = 16,
  parameter int unsigned N_F_W   = 14
) (
  input logic                 clk,
  input logic                 rst_n,
  tanh_backward_block_if.slave bus
);

  localparam int unsigned IdxW  = 5;
  localparam int unsigned SqW   = 2 * N_LEN_W;
  localparam int unsigned DerW  = N_F_W + 1;
  // Signed dy times the zero-extended unsigned derivative.
  localparam int unsigned PW    = N_LEN + DerW + 1;
  localparam int unsigned AccW  = PW + 1;
  // Product carries N_F + N_F_W fraction bits; drop down to N_F.
  localparam int unsigned Shift = (N_F + N_F_W) - N_F;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(HID_DIM - 1);
  localparam logic signed [SqW:0] One = (SqW + 1)'(64'd1 << (2 * N_F_W));
  localparam logic signed [AccW-1:0] ResMax = AccW'((64'd1 << (N_LEN - 1)) - 64'd1);
  localparam logic signed [AccW-1:0] ResMin = -AccW'(64'd1 << (N_LEN - 1));
`ifdef TANH_BACKWARD_ROUND_EN
  localparam logic signed [AccW-1:0] Rnd = AccW'(64'd1 << (N_F_W - 1));
`else
  localparam logic signed [AccW-1:0] Rnd = '0;
`endif

  logic [IdxW-1:0] idx_q, idx_d;

  logic                      s1_live_q, s2_live_q, s3_live_q, wr_live_q;
  logic [IdxW-1:0]           s1_idx_q, s2_idx_q, s3_idx_q, wr_idx_q;
  logic signed [N_LEN-1:0]   s1_dy_q, s2_dy_q;
  logic signed [N_LEN_W-1:0] s1_y_q;
  logic [DerW-1:0]           s2_deriv_q;
  logic signed [PW-1:0]      s3_prod_q;

  logic [N_LEN-1:0] q_q [HID_DIM];

  logic signed [N_LEN-1:0]   dy_sel;
  logic signed [N_LEN_W-1:0] y_sel;
  logic signed [SqW-1:0]     sq;
  logic signed [SqW:0]       om;
  logic [DerW-1:0]           deriv;
  logic signed [PW-1:0]      prod;
  logic signed [AccW-1:0]    acc, shifted;
  logic [N_LEN-1:0]          res;

  always_comb begin
    idx_d = '0;
    if (bus.run) begin
      idx_d = (idx_q == LastIdx) ? idx_q : idx_q + IdxW'(1);
    end
  end

  // Mux straight off the live ports; upstream holds d/y stable during the job.
  always_comb begin
    dy_sel = bus.d[idx_q * N_LEN +: N_LEN];
    y_sel  = bus.y[idx_q * N_LEN_W +: N_LEN_W];
  end

  always_comb begin
    sq    = s1_y_q * s1_y_q;
    om    = One - {sq[SqW-1], sq};
    deriv = om[SqW] ? '0 : om[N_F_W +: DerW];
    prod  = s2_dy_q * $signed({1'b0, s2_deriv_q});
  end

  // Final shift with saturation; saturation never fires when truncating.
  always_comb begin
    acc     = {s3_prod_q[PW-1], s3_prod_q} + Rnd;
    shifted = acc >>> Shift;
    if (shifted > ResMax) begin
      res = ResMax[N_LEN-1:0];
    end else if (shifted < ResMin) begin
      res = ResMin[N_LEN-1:0];
    end else begin
      res = shifted[N_LEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= '0;
      s1_live_q  <= 1'b0;
      s2_live_q  <= 1'b0;
      s3_live_q  <= 1'b0;
      wr_live_q  <= 1'b0;
      s1_idx_q   <= '0;
      s2_idx_q   <= '0;
      s3_idx_q   <= '0;
      wr_idx_q   <= '0;
      s1_dy_q    <= '0;
      s2_dy_q    <= '0;
      s1_y_q     <= '0;
      s2_deriv_q <= '0;
      s3_prod_q  <= '0;
    end else begin
      idx_q      <= idx_d;
      s1_live_q  <= bus.run;
      s2_live_q  <= bus.run & s1_live_q;
      s3_live_q  <= bus.run & s2_live_q;
      wr_live_q  <= bus.run & s3_live_q;
      s1_idx_q   <= idx_q;
      s2_idx_q   <= s1_idx_q;
      s3_idx_q   <= s2_idx_q;
      wr_idx_q   <= s3_idx_q;
      s1_dy_q    <= dy_sel;
      s2_dy_q    <= s1_dy_q;
      s1_y_q     <= y_sel;
      s2_deriv_q <= deriv;
      s3_prod_q  <= prod;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HID_DIM; i++) begin
        q_q[i] <= '0;
      end
    end else if (s3_live_q) begin
      q_q[s3_idx_q] <= res;
    end
  end

  // wr_* trails the write by one edge, so valid rises once the last element is in q.
  assign bus.valid = bus.run & wr_live_q & (wr_idx_q == LastIdx);

  for (genvar g = 0; g < HID_DIM; g++) begin : g_pack
    assign bus.q[g * N_LEN +: N_LEN] = q_q[g];
  end

  logic unused_bits;
  assign unused_bits = ^{om[N_F_W-1:0], om[SqW:N_F_W+DerW], shifted[AccW-1:N_LEN]};

endmodule

// File: tb/tb_tanh_backward_block.sv
// Directed + random bench for tanh_backward_block against an integer reference model.
module tb_tanh_backward_block;
  localparam int HID = 24;
  localparam int LAT = HID + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [HID*16-1:0] dv, yv;

  tanh_backward_block_if #(.HID_DIM(HID), .N_LEN(16), .N_LEN_W(16)) bus ();

  tanh_backward_block #(
    .HID_DIM(HID), .N_LEN(16), .N_F(8), .N_LEN_W(16), .N_F_W(14)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // dx = floor(dy * floor(max(0, 1 - y^2) in Q14) / 2^14), optional half-up rounding, saturated.
  function automatic logic [15:0] model(input logic [15:0] dy, input logic [15:0] y);
    longint sy, sd, om, der, p, r;
    sy = longint'($signed(y));
    sd = longint'($signed(dy));
    om = (longint'(1) <<< 28) - sy * sy;
    if (om < 0) om = 0;
    der = om / 16384;
    p = sd * der;
`ifdef TANH_BACKWARD_ROUND_EN
    p = p + 8192;
`endif
    r = p >>> 14;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag);
    for (int i = 0; i < HID; i++) begin
      check($sformatf("%s_q%0d", tag, i), 32'(bus.q[i*16 +: 16]),
            32'(model(dv[i*16 +: 16], yv[i*16 +: 16])));
    end
  endtask

  // Counts posedges until valid, bounded.
  task automatic wait_valid(output int n);
    n = 0;
    while (n < 200) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.valid) break;
    end
  endtask

  task automatic run_job(input string tag);
    int n;
    @(negedge clk);
    bus.d = dv;
    bus.y = yv;
    bus.run = 1'b1;
    #1;
    check({tag, "_valid_c0"}, 32'(bus.valid), 32'd0);
    wait_valid(n);
    check({tag, "_latency"}, n, LAT);
    check_q(tag);
    @(posedge clk);
    #1;
    check({tag, "_valid_hold"}, 32'(bus.valid), 32'd1);
    check({tag, "_last_hold"}, 32'(bus.q[(HID-1)*16 +: 16]),
          32'(model(dv[(HID-1)*16 +: 16], yv[(HID-1)*16 +: 16])));
    @(negedge clk);
    bus.run = 1'b0;
    #1;
    check({tag, "_valid_drop"}, 32'(bus.valid), 32'd0);
    @(posedge clk);
  endtask

  task automatic fill(input logic [15:0] d0, input logic [15:0] d1,
                      input logic [15:0] y0, input logic [15:0] y1);
    for (int i = 0; i < HID; i++) begin
      dv[i*16 +: 16] = (i % 2 == 0) ? d0 : d1;
      yv[i*16 +: 16] = (i % 2 == 0) ? y0 : y1;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < HID; i++) begin
      dv[i*16 +: 16] = 16'($urandom);
      yv[i*16 +: 16] = 16'($urandom_range(0, 2)) == 0 ? 16'($urandom) :
                       16'($signed(16'($urandom_range(0, 32768))) - 16'sd16384);
    end
  endtask

  initial begin
    int n;
    bus.run = 1'b0;
    bus.d = '0;
    bus.y = '0;
    dv = '0;
    yv = '0;
    #12;
    check("reset_valid", 32'(bus.valid), 32'd0);
    check("reset_q_zero", 32'(|bus.q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    fill(16'h0100, 16'h0100, 16'h0000, 16'h0000);
    run_job("y0");
    check("y0_const", 32'(bus.q[5*16 +: 16]), 32'h0100);

    fill(16'h7FFF, 16'h7FFF, 16'h4000, 16'hC000);
    run_job("pm1");
    check("pm1_const", 32'(bus.q[1*16 +: 16]), 32'h0000);

    fill(16'h0200, 16'hFE00, 16'h2000, 16'h2000);
    run_job("half");
    check("half_const0", 32'(bus.q[0 +: 16]), 32'h0180);
    check("half_const1", 32'(bus.q[16 +: 16]), 32'hFE80);

    fill(16'h0100, 16'h0100, 16'h6000, 16'h6000);
    run_job("oor");
    check("oor_const", 32'(bus.q[2*16 +: 16]), 32'h0000);

    fill(16'h0001, 16'hFFFF, 16'h2000, 16'h2000);
    run_job("lsb");
`ifdef TANH_BACKWARD_ROUND_EN
    check("lsb_pos_const", 32'(bus.q[0 +: 16]), 32'h0001);
`else
    check("lsb_pos_const", 32'(bus.q[0 +: 16]), 32'h0000);
`endif
    check("lsb_neg_const", 32'(bus.q[16 +: 16]), 32'hFFFF);

    for (int k = 0; k < 3; k++) begin
      fill_rand();
      run_job($sformatf("rnd%0d", k));
    end

    // Abort mid-vector at cycle 5, one low cycle, then a new job.
    fill_rand();
    @(negedge clk);
    bus.d = dv;
    bus.y = yv;
    bus.run = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.run = 1'b0;
    #1;
    check("abort_valid", 32'(bus.valid), 32'd0);
    @(posedge clk);
    fill_rand();
    run_job("abort_new");

    // Reset pulse after valid with run held high.
    fill_rand();
    @(negedge clk);
    bus.d = dv;
    bus.y = yv;
    bus.run = 1'b1;
    wait_valid(n);
    check("rst_pre_valid", 32'(bus.valid), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_valid", 32'(bus.valid), 32'd0);
    check("rst_q_zero", 32'(|bus.q), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_valid(n);
    check("rst_latency", n, LAT);
    check_q("rst_job");
    @(negedge clk);
    bus.run = 1'b0;
    @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
